mandel_pixel_scheduler: RTL

- Frame-level sequencer feeding NUM_ENGINES depth_calculator_LUT engines.
- Walks every pixel of an HRES x VRES frame and generates re_c/im_c by incremental fixed-point stepping.
- Dispatches each pixel to a free engine, captures its color, and emits a tagged (x, y, color) stream with valid/ready to the framebuffer writer.
- Output order is completion order, not raster order.

---
 rtl/mandel_pixel_scheduler.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mandel_pixel_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mandel_pixel_scheduler                                           |
// | Brief   : Frame sequencer that steps re/im per pixel, dispatches to free   |
// |           depth engines and streams tagged (x, y, color) results out.      |
// |           Optional frame cycle counter: define SCHED_PERF_CNT_EN.          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mandel_pixel_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int FRAC        = 60,
    parameter int WORD_LENGTH = 64,
    parameter int HRES        = 640,
    parameter int VRES        = 480
) (
    input  logic                               sysclk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [WORD_LENGTH-1:0]             re_origin,
    input  logic [WORD_LENGTH-1:0]             im_origin,
    input  logic [WORD_LENGTH-1:0]             step,
    output logic                               busy,
    output logic                               frame_done,
    output logic [NUM_ENGINES-1:0]             eng_start,
    output logic [NUM_ENGINES*WORD_LENGTH-1:0] eng_re_c,
    output logic [NUM_ENGINES*WORD_LENGTH-1:0] eng_im_c,
    input  logic [NUM_ENGINES-1:0]             eng_done,
    input  logic [NUM_ENGINES*24-1:0]          eng_color,
    output logic                               pix_valid,
    input  logic                               pix_ready,
    output logic [10:0]                        pix_x,
    output logic [10:0]                        pix_y,
    output logic [23:0]                        pix_color,
    output logic [31:0]                        frame_cycles
);

    localparam int          c_IDX_W  = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [10:0] c_X_LAST = 11'(HRES - 1);
    localparam logic [10:0] c_Y_LAST = 11'(VRES - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [1:0] c_SL_FREE    = 2'd0;
    localparam logic [1:0] c_SL_BUSY    = 2'd1;
    localparam logic [1:0] c_SL_CAPTURE = 2'd2;
    localparam logic [1:0] c_SL_HOLD    = 2'd3;

    // Reject configurations the fixed-width coordinate/tag paths cannot represent.
    if (FRAC >= WORD_LENGTH || NUM_ENGINES < 1 || NUM_ENGINES > 8 ||
        HRES < 1 || HRES > 2048 || VRES < 1 || VRES > 2048) begin : g_param_check
        $error("mandel_pixel_scheduler: illegal parameter combination");
    end

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [1:0]             r_slot_st   [NUM_ENGINES];
    logic [1:0]             w_slot_next [NUM_ENGINES];
    logic [10:0]            r_tag_x     [NUM_ENGINES];
    logic [10:0]            r_tag_y     [NUM_ENGINES];
    logic [23:0]            r_color     [NUM_ENGINES];

    logic [10:0]            r_x;
    logic [10:0]            r_y;
    logic [WORD_LENGTH-1:0] r_re;
    logic [WORD_LENGTH-1:0] r_im;
    logic [WORD_LENGTH-1:0] r_re_origin;
    logic [WORD_LENGTH-1:0] r_step;

    logic [c_IDX_W-1:0]     r_out_slot;
    logic [c_IDX_W-1:0]     r_rr_ptr;
    logic [c_IDX_W-1:0]     w_free_idx;
    logic [c_IDX_W-1:0]     w_grant_idx;
    logic [c_IDX_W-1:0]     w_rr_idx;
    logic [c_IDX_W-1:0]     w_rr_next;
    logic                   w_free_found;
    logic                   w_grant_found;
    logic                   w_all_free;
    logic                   w_dispatch;
    logic                   w_last_pix;
    logic                   w_accept_start;
    logic                   w_out_load;
    logic                   w_out_accept;

    assign w_accept_start = (r_state == c_ST_IDLE) && start;
    assign w_dispatch     = (r_state == c_ST_RUN) && w_free_found;
    assign w_last_pix     = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
    assign w_out_accept   = pix_valid && pix_ready;
    assign w_out_load     = !pix_valid || pix_ready;

    assign busy       = (r_state == c_ST_RUN) || (r_state == c_ST_DRAIN);
    assign frame_done = (r_state == c_ST_DONE);

    // Lowest-index FREE slot wins; descending scan lets the lowest overwrite.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_all_free   = 1'b1;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (r_slot_st[i] == c_SL_FREE) begin
                w_free_found = 1'b1;
                w_free_idx   = c_IDX_W'(i);
            end else begin
                w_all_free = 1'b0;
            end
        end
    end

    // Round-robin over HOLD slots, skipping the one already sitting in the output register.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_rr_idx      = '0;
        for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
            w_rr_idx = c_IDX_W'((int'(r_rr_ptr) + k) % NUM_ENGINES);
            if (r_slot_st[w_rr_idx] == c_SL_HOLD && !(pix_valid && r_out_slot == w_rr_idx)) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_rr_idx;
            end
        end
        w_rr_next = (w_grant_idx == c_IDX_W'(NUM_ENGINES - 1)) ? '0 : w_grant_idx + c_IDX_W'(1);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_state_next = c_ST_RUN;
            c_ST_RUN:   if (w_dispatch && w_last_pix) w_state_next = c_ST_DRAIN;
            c_ST_DRAIN: if (w_all_free && !pix_valid) w_state_next = c_ST_DONE;
            c_ST_DONE:  w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_ENGINES; i++) begin
            w_slot_next[i] = r_slot_st[i];
            case (r_slot_st[i])
                c_SL_FREE:    if (w_dispatch && w_free_idx == c_IDX_W'(i)) w_slot_next[i] = c_SL_BUSY;
                c_SL_BUSY:    if (eng_done[i]) w_slot_next[i] = c_SL_CAPTURE;
                c_SL_CAPTURE: w_slot_next[i] = c_SL_HOLD;
                c_SL_HOLD:    if (w_out_accept && r_out_slot == c_IDX_W'(i)) w_slot_next[i] = c_SL_FREE;
                default:      w_slot_next[i] = c_SL_FREE;
            endcase
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_re        <= '0;
            r_im        <= '0;
            r_re_origin <= '0;
            r_step      <= '0;
        end else if (w_accept_start) begin
            r_x         <= '0;
            r_y         <= '0;
            r_re        <= re_origin;
            r_im        <= im_origin;
            r_re_origin <= re_origin;
            r_step      <= step;
        end else if (w_dispatch) begin
            if (r_x == c_X_LAST) begin
                r_x  <= '0;
                r_y  <= r_y + 11'd1;
                r_re <= r_re_origin;
                r_im <= r_im - r_step;
            end else begin
                r_x  <= r_x + 11'd1;
                r_re <= r_re + r_step;
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            eng_start <= '0;
            eng_re_c  <= '0;
            eng_im_c  <= '0;
            for (int i = 0; i < NUM_ENGINES; i++) begin
                r_slot_st[i] <= c_SL_FREE;
                r_tag_x[i]   <= '0;
                r_tag_y[i]   <= '0;
                r_color[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
                r_slot_st[i] <= w_slot_next[i];
                eng_start[i] <= w_dispatch && (w_free_idx == c_IDX_W'(i));
                if (w_dispatch && w_free_idx == c_IDX_W'(i)) begin
                    eng_re_c[i*WORD_LENGTH +: WORD_LENGTH] <= r_re;
                    eng_im_c[i*WORD_LENGTH +: WORD_LENGTH] <= r_im;
                    r_tag_x[i] <= r_x;
                    r_tag_y[i] <= r_y;
                end
                if (r_slot_st[i] == c_SL_CAPTURE) r_color[i] <= eng_color[i*24 +: 24];
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_color  <= '0;
            r_out_slot <= '0;
            r_rr_ptr   <= '0;
        end else if (w_out_load) begin
            pix_valid <= w_grant_found;
            if (w_grant_found) begin
                pix_x      <= r_tag_x[w_grant_idx];
                pix_y      <= r_tag_y[w_grant_idx];
                pix_color  <= r_color[w_grant_idx];
                r_out_slot <= w_grant_idx;
                r_rr_ptr   <= w_rr_next;
            end
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] r_frame_cycles;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)                                  r_frame_cycles <= '0;
        else if (w_accept_start)                    r_frame_cycles <= '0;
        else if (busy && r_frame_cycles != 32'hFFFF_FFFF) r_frame_cycles <= r_frame_cycles + 32'd1;
    end

    assign frame_cycles = r_frame_cycles;
`else
    assign frame_cycles = 32'd0;
`endif

endmodule
`default_nettype wire
